// File: rtl/matrix_alu_sequencer.sv
// Transaction sequencer for the 6x6 fp32 matrix ALU: gathers a/b from an operand
// word stream, runs one ALU operation per command and streams the z words back out.
module matrix_alu_sequencer #(
  parameter int MAT_N   = 6,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [WORD_W-1:0]             cmd_k,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [WORD_W-1:0]             s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [WORD_W-1:0]             m_data,
  output logic                          m_last,
  output logic                          alu_start,
  output logic [1:0]                    alu_op,
  output logic [WORD_W-1:0]             alu_k,
  output logic [MAT_N*MAT_N*WORD_W-1:0] alu_a,
  output logic [MAT_N*WORD_W-1:0]       alu_b,
  input  logic                          alu_finish,
  input  logic [MAT_N*WORD_W-1:0]       alu_z,
  output logic                          busy,
  output logic                          err_op,
  output logic                          err_timeout
);

  localparam int CNT_W = $clog2(MAT_N*MAT_N);
  localparam int IDX_W = $clog2(MAT_N);
  localparam int TO_W  = $clog2(TIMEOUT+1);
  localparam logic [CNT_W-1:0] A_LAST  = CNT_W'(MAT_N*MAT_N - 1);
  localparam logic [CNT_W-1:0] B_LAST  = CNT_W'(MAT_N - 1);
  localparam logic [IDX_W-1:0] Z_LAST  = IDX_W'(MAT_N - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    DRAIN  = 3'd5
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]       cnt;
  logic [TO_W-1:0]        tcnt;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_nxt;
  logic [MAT_N*WORD_W-1:0] zbuf;
  logic cmd_fire, op_legal, s_fire, m_fire;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign op_legal = (cmd_op == 2'b01) || (cmd_op == 2'b10);
  assign s_fire   = s_valid && s_ready;
  assign m_fire   = m_valid && m_ready;
  assign idx_nxt  = idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cmd_fire && op_legal) next_state = LOAD_A;
        else                      next_state = IDLE;
      end
      LOAD_A: begin
        if (s_fire && (cnt == A_LAST)) next_state = LOAD_B;
        else                           next_state = LOAD_A;
      end
      LOAD_B: begin
        if (s_fire && (cnt == B_LAST)) next_state = START;
        else                           next_state = LOAD_B;
      end
      START: next_state = WAIT;
      // a finish in the last allowed cycle wins over the timeout
      WAIT: begin
        if (alu_finish)             next_state = DRAIN;
        else if (tcnt == TO_LAST)   next_state = IDLE;
        else                        next_state = WAIT;
      end
      DRAIN: begin
        if (m_fire && m_last) next_state = IDLE;
        else                  next_state = DRAIN;
      end
      default: next_state = IDLE;
    endcase
  end

  // Control outputs are decoded from next_state so they line up with the state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_ready   <= 1'b0;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      alu_start   <= 1'b0;
      m_valid     <= 1'b0;
      err_op      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      cmd_ready   <= (next_state == IDLE);
      s_ready     <= (next_state == LOAD_A) || (next_state == LOAD_B);
      busy        <= (next_state != IDLE);
      alu_start   <= (next_state == START);
      m_valid     <= (next_state == DRAIN);
      err_op      <= (state == IDLE) && cmd_fire && !op_legal;
      err_timeout <= (state == WAIT) && !alu_finish && (tcnt == TO_LAST);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alu_op <= 2'b00;
      alu_k  <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      cnt    <= '0;
      tcnt   <= '0;
      idx    <= '0;
      zbuf   <= '0;
      m_data <= '0;
      m_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire && op_legal) begin
            alu_op <= cmd_op;
            alu_k  <= cmd_k;
            cnt    <= '0;
          end
        end
        LOAD_A: begin
          if (s_fire) begin
            alu_a[WORD_W*int'(cnt) +: WORD_W] <= s_data;
            cnt <= (cnt == A_LAST) ? '0 : cnt + CNT_W'(1);
          end
        end
        LOAD_B: begin
          if (s_fire) begin
            alu_b[WORD_W*int'(cnt[IDX_W-1:0]) +: WORD_W] <= s_data;
            cnt <= cnt + CNT_W'(1);
          end
        end
        START: tcnt <= '0;
        WAIT: begin
          tcnt <= tcnt + TO_W'(1);
          if (alu_finish) begin
            zbuf   <= alu_z;
            idx    <= '0;
            m_data <= alu_z[WORD_W-1:0];
            m_last <= (Z_LAST == '0);
          end
        end
        // m_data/m_last only move on a handshake, so they hold through back-pressure
        DRAIN: begin
          if (m_fire) begin
            if (m_last) begin
              idx    <= '0;
              m_data <= '0;
              m_last <= 1'b0;
            end else begin
              idx    <= idx_nxt;
              m_data <= zbuf[WORD_W*int'(idx_nxt) +: WORD_W];
              m_last <= (idx_nxt == Z_LAST);
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
